// File: rtl/param_bus_datapath.sv
// Single-bus datapath: NREG registers, accumulator, ALU and a req/ack memory port with stall FSM.
// Optional PBD_ZERO_FLAG_EN adds zero_flag and turns ALU op 7 into CMP (DEC is then unavailable).
module param_bus_datapath #(
   parameter int DATA_W  = 24,
   parameter int ADDR_W  = 24,
   parameter int NREG    = 12,
   parameter int MAR_IDX = 1,
   parameter int MDR_IDX = 2,
   parameter int SEL_W   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              uop_valid,
   output logic              uop_ready,
   input  logic [SEL_W-1:0]  uop_src,
   input  logic              uop_src_imm,
   input  logic [DATA_W-1:0] uop_imm,
   input  logic              uop_alu_en,
   input  logic [2:0]        uop_alu_op,
   input  logic [NREG-1:0]   uop_dst,
   input  logic              uop_ac_wr,
   input  logic              uop_pc_inc,
   input  logic              uop_mem_rd,
   input  logic              uop_mem_wr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] ac_out,
   output logic [DATA_W-1:0] pc_out,
   output logic              neg_flag,
   output logic              proto_err
`ifdef PBD_ZERO_FLAG_EN
   ,
   output logic              zero_flag
`endif
);

   // state   | meaning
   // ST_IDLE | accepting micro-ops, ALU ops complete in one cycle
   // ST_MEM  | memory transfer outstanding, waiting for mem_ack
   typedef enum logic {ST_IDLE, ST_MEM} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   regs_q [NREG];
   logic [DATA_W-1:0]   regs_d [NREG];
   logic [DATA_W-1:0]   ac_q, ac_d;
   logic                neg_q, neg_d;
   logic                perr_q, perr_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
`ifdef PBD_ZERO_FLAG_EN
   logic                zero_q, zero_d;
`endif

   logic                accept, is_mem, src_ok, is_cmp;
   logic [DATA_W-1:0]   bus_b, alu_y, bus_c;

   assign uop_ready = (state_q == ST_IDLE);
   assign accept    = uop_valid && uop_ready;
   assign is_mem    = uop_mem_rd || uop_mem_wr;
   assign src_ok    = (uop_src < SEL_W'(NREG));

   always_comb begin
      bus_b = '0;
      if (uop_src_imm)
         bus_b = uop_imm;
      else if (src_ok)
         bus_b = regs_q[uop_src];
   end

   always_comb begin
      alu_y = bus_b;
      case (uop_alu_op)
         3'd0: alu_y = bus_b;
         3'd1: alu_y = ac_q + bus_b;
         3'd2: alu_y = ac_q - bus_b;
         3'd3: alu_y = ac_q * bus_b;
         3'd4: alu_y = ac_q & bus_b;
         3'd5: alu_y = ac_q | bus_b;
         3'd6: alu_y = bus_b + DATA_W'(1);
         3'd7: begin
`ifdef PBD_ZERO_FLAG_EN
            alu_y = ac_q - bus_b;
`else
            alu_y = bus_b - DATA_W'(1);
`endif
         end
         default: alu_y = bus_b;
      endcase
   end

`ifdef PBD_ZERO_FLAG_EN
   assign is_cmp = uop_alu_en && (uop_alu_op == 3'd7);
`else
   assign is_cmp = 1'b0;
`endif

   assign bus_c = uop_alu_en ? alu_y : bus_b;

   always_comb begin
      state_d     = state_q;
      regs_d      = regs_q;
      ac_d        = ac_q;
      neg_d       = neg_q;
      perr_d      = perr_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef PBD_ZERO_FLAG_EN
      zero_d      = zero_q;
`endif
      if (accept && !uop_src_imm && !src_ok)
         perr_d = 1'b1;
      if (accept && !is_mem) begin
         for (int i = 0; i < NREG; i++)
            if (uop_dst[i]) regs_d[i] = bus_c;
         // an explicit PC write wins over the increment
         if (!uop_dst[0] && uop_pc_inc)
            regs_d[0] = regs_q[0] + DATA_W'(1);
         if (uop_ac_wr) begin
            if (!is_cmp) ac_d = bus_c;
            neg_d = bus_c[DATA_W-1];
`ifdef PBD_ZERO_FLAG_EN
            zero_d = (bus_c == '0);
`endif
         end
      end
      if (accept && is_mem) begin
         state_d     = ST_MEM;
         mem_req_d   = 1'b1;
         mem_we_d    = uop_mem_wr;
         mem_addr_d  = regs_q[MAR_IDX][ADDR_W-1:0];
         mem_wdata_d = regs_q[MDR_IDX];
         if (uop_mem_rd && uop_mem_wr) perr_d = 1'b1;
      end
      if (mem_ack) begin
         if (state_q == ST_MEM) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (!mem_we_q) regs_d[MDR_IDX] = mem_rdata;
         end else begin
            perr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         ac_q        <= '0;
         neg_q       <= 1'b0;
         perr_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef PBD_ZERO_FLAG_EN
         zero_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         regs_q      <= regs_d;
         ac_q        <= ac_d;
         neg_q       <= neg_d;
         perr_q      <= perr_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef PBD_ZERO_FLAG_EN
         zero_q      <= zero_d;
`endif
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign ac_out    = ac_q;
   assign pc_out    = regs_q[0];
   assign neg_flag  = neg_q;
   assign proto_err = perr_q;
`ifdef PBD_ZERO_FLAG_EN
   assign zero_flag = zero_q;
`endif

endmodule

// File: tb/tb_param_bus_datapath.sv
// Scoreboard bench for param_bus_datapath: a small reference model pushes expectations
// as micro-ops are driven; they are popped and compared when the DUT result appears.
module tb_param_bus_datapath;

   typedef struct packed {
      logic [23:0] ac;
      logic        neg;
      logic        zero;
      logic [23:0] pc;
   } exp_t;

   typedef struct packed {
      logic [23:0] addr;
      logic        we;
      logic [23:0] wdata;
   } mexp_t;

   logic        clk, reset_n;
   logic        uop_valid, uop_ready;
   logic [3:0]  uop_src;
   logic        uop_src_imm;
   logic [23:0] uop_imm;
   logic        uop_alu_en;
   logic [2:0]  uop_alu_op;
   logic [11:0] uop_dst;
   logic        uop_ac_wr, uop_pc_inc, uop_mem_rd, uop_mem_wr;
   logic        mem_req, mem_we, mem_ack;
   logic [23:0] mem_addr, mem_wdata, mem_rdata;
   logic [23:0] ac_out, pc_out;
   logic        neg_flag, proto_err;
`ifdef PBD_ZERO_FLAG_EN
   logic        zero_flag;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [23:0] m_regs [12];
   logic [23:0] m_ac;
   logic        m_neg, m_zero, m_perr;
   exp_t        exp_q [$];
   mexp_t       mexp_q [$];

   param_bus_datapath dut (
      .clk(clk), .reset_n(reset_n),
      .uop_valid(uop_valid), .uop_ready(uop_ready),
      .uop_src(uop_src), .uop_src_imm(uop_src_imm), .uop_imm(uop_imm),
      .uop_alu_en(uop_alu_en), .uop_alu_op(uop_alu_op), .uop_dst(uop_dst),
      .uop_ac_wr(uop_ac_wr), .uop_pc_inc(uop_pc_inc),
      .uop_mem_rd(uop_mem_rd), .uop_mem_wr(uop_mem_wr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .ac_out(ac_out), .pc_out(pc_out), .neg_flag(neg_flag), .proto_err(proto_err)
`ifdef PBD_ZERO_FLAG_EN
      , .zero_flag(zero_flag)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 12; i++) m_regs[i] = '0;
      m_ac = '0; m_neg = 1'b0; m_zero = 1'b0; m_perr = 1'b0;
   endtask

   task automatic idle();
      uop_valid = 1'b0; uop_mem_rd = 1'b0; uop_mem_wr = 1'b0;
      uop_dst = '0; uop_ac_wr = 1'b0; uop_pc_inc = 1'b0; uop_src_imm = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic issue_alu(input logic s_imm, input logic [3:0] src, input logic [23:0] imm,
                            input logic alu_en, input logic [2:0] op, input logic [11:0] dst,
                            input logic ac_wr, input logic pc_inc);
      logic [23:0] b, y, c;
      logic        cmp;
      exp_t        e;
      uop_src_imm = s_imm; uop_src = src; uop_imm = imm; uop_alu_en = alu_en;
      uop_alu_op = op; uop_dst = dst; uop_ac_wr = ac_wr; uop_pc_inc = pc_inc;
      uop_mem_rd = 1'b0; uop_mem_wr = 1'b0; uop_valid = 1'b1;
      if (s_imm) b = imm;
      else if (src < 4'd12) b = m_regs[src];
      else begin b = '0; m_perr = 1'b1; end
      cmp = 1'b0;
      case (op)
         3'd0: y = b;
         3'd1: y = m_ac + b;
         3'd2: y = m_ac - b;
         3'd3: y = m_ac * b;
         3'd4: y = m_ac & b;
         3'd5: y = m_ac | b;
         3'd6: y = b + 24'd1;
         default: begin
`ifdef PBD_ZERO_FLAG_EN
            y = m_ac - b; cmp = alu_en;
`else
            y = b - 24'd1;
`endif
         end
      endcase
      c = alu_en ? y : b;
      if (ac_wr) begin
         if (!cmp) m_ac = c;
         m_neg = c[23]; m_zero = (c == 24'd0);
      end
      for (int i = 0; i < 12; i++) if (dst[i]) m_regs[i] = c;
      if (!dst[0] && pc_inc) m_regs[0] = m_regs[0] + 24'd1;
      e.ac = m_ac; e.neg = m_neg; e.zero = m_zero; e.pc = m_regs[0];
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++; if (ac_out !== e.ac) begin n_bad++; $display("FAIL alu_ac op=%0d got=%h want=%h", op, ac_out, e.ac); end
      n_cmp++; if (neg_flag !== e.neg) begin n_bad++; $display("FAIL alu_neg op=%0d got=%b want=%b", op, neg_flag, e.neg); end
      n_cmp++; if (pc_out !== e.pc) begin n_bad++; $display("FAIL alu_pc got=%h want=%h", pc_out, e.pc); end
      n_cmp++; if (uop_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ready got=%b want=1", uop_ready); end
`ifdef PBD_ZERO_FLAG_EN
      n_cmp++; if (zero_flag !== e.zero) begin n_bad++; $display("FAIL alu_zero got=%b want=%b", zero_flag, e.zero); end
`endif
   endtask

   task automatic mem_op(input logic rd, input logic wr, input int delay, input logic [23:0] rdata);
      mexp_t m;
      m.addr = m_regs[1]; m.we = wr; m.wdata = m_regs[2];
      mexp_q.push_back(m);
      if (rd && wr) m_perr = 1'b1;
      uop_src_imm = 1'b1; uop_dst = 12'hFFF; uop_ac_wr = 1'b1; uop_pc_inc = 1'b1;
      uop_mem_rd = rd; uop_mem_wr = wr; uop_valid = 1'b1;
      @(posedge clk); #1;
      uop_valid = 1'b0; uop_mem_rd = 1'b0; uop_mem_wr = 1'b0;
      uop_dst = '0; uop_ac_wr = 1'b0; uop_pc_inc = 1'b0;
      m = mexp_q.pop_front();
      for (int c = 1; c <= delay; c++) begin
         n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL mem_req_hi cyc=%0d got=%b want=1", c, mem_req); end
         n_cmp++; if (uop_ready !== 1'b0) begin n_bad++; $display("FAIL mem_ready_lo cyc=%0d got=%b want=0", c, uop_ready); end
         n_cmp++; if (mem_addr !== m.addr) begin n_bad++; $display("FAIL mem_addr cyc=%0d got=%h want=%h", c, mem_addr, m.addr); end
         n_cmp++; if (mem_we !== m.we) begin n_bad++; $display("FAIL mem_we cyc=%0d got=%b want=%b", c, mem_we, m.we); end
         if (m.we) begin
            n_cmp++; if (mem_wdata !== m.wdata) begin n_bad++; $display("FAIL mem_wdata cyc=%0d got=%h want=%h", c, mem_wdata, m.wdata); end
         end
         if (c == delay) begin mem_ack = 1'b1; mem_rdata = rdata; end
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
      if (rd && !wr) m_regs[2] = rdata;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL mem_req_done got=%b want=0", mem_req); end
      n_cmp++; if (uop_ready !== 1'b1) begin n_bad++; $display("FAIL mem_ready_done got=%b want=1", uop_ready); end
      n_cmp++; if (proto_err !== m_perr) begin n_bad++; $display("FAIL mem_perr got=%b want=%b", proto_err, m_perr); end
      n_cmp++; if (pc_out !== m_regs[0]) begin n_bad++; $display("FAIL mem_pc_untouched got=%h want=%h", pc_out, m_regs[0]); end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      n_cmp++; if (ac_out !== 24'd0) begin n_bad++; $display("FAIL rst_ac got=%h want=0", ac_out); end
      n_cmp++; if (pc_out !== 24'd0) begin n_bad++; $display("FAIL rst_pc got=%h want=0", pc_out); end
      n_cmp++; if (neg_flag !== 1'b0) begin n_bad++; $display("FAIL rst_neg got=%b want=0", neg_flag); end
      n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL rst_perr got=%b want=0", proto_err); end
      n_cmp++; if (uop_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b want=1", uop_ready); end
      n_cmp++; if ({mem_req, mem_we} !== 2'b00) begin n_bad++; $display("FAIL rst_mem got=%b want=00", {mem_req, mem_we}); end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      issue_alu(1, 0, 24'd5, 1, 3'd0, 12'h000, 1, 0);
      issue_alu(1, 0, 24'd7, 1, 3'd1, 12'h000, 1, 0);
      idle();
      n_cmp++; if (ac_out !== 24'd12) begin n_bad++; $display("FAIL b2b_ac got=%h want=00000c", ac_out); end
   endtask

   task automatic test_sub_neg();
      issue_alu(1, 0, 24'd3, 1, 3'd0, 12'h000, 1, 0);
      issue_alu(1, 0, 24'd4, 1, 3'd2, 12'h000, 1, 0);
      idle();
      n_cmp++; if ({neg_flag, ac_out} !== {1'b1, 24'hFFFFFF}) begin n_bad++; $display("FAIL sub_neg got=%b/%h want=1/ffffff", neg_flag, ac_out); end
`ifdef PBD_ZERO_FLAG_EN
      issue_alu(1, 0, 24'd3, 1, 3'd0, 12'h000, 1, 0);
      issue_alu(1, 0, 24'd3, 1, 3'd7, 12'h000, 1, 0);
      idle();
`endif
   endtask

   task automatic test_mem_read();
      issue_alu(1, 0, 24'h10, 0, 3'd0, 12'h002, 0, 0);
      idle();
      mem_op(1, 0, 3, 24'hABCDEF);
      issue_alu(0, 4'd2, 24'd0, 1, 3'd0, 12'h000, 1, 0);
      idle();
   endtask

   task automatic test_pc();
      issue_alu(1, 0, 24'h40, 0, 3'd0, 12'h001, 0, 1);
      issue_alu(1, 0, 24'hFFFFFF, 0, 3'd0, 12'h001, 0, 0);
      issue_alu(1, 0, 24'd0, 0, 3'd0, 12'h000, 0, 1);
      issue_alu(1, 0, 24'd0, 0, 3'd0, 12'h000, 0, 1);
      idle();
   endtask

   task automatic test_alu_ops();
      issue_alu(1, 0, 24'h123456, 1, 3'd0, 12'h000, 1, 0);
      issue_alu(1, 0, 24'h001000, 1, 3'd3, 12'h020, 1, 0);
      issue_alu(1, 0, 24'h0F0F0F, 1, 3'd4, 12'h000, 1, 0);
      issue_alu(1, 0, 24'h800001, 1, 3'd5, 12'h000, 1, 0);
      issue_alu(1, 0, 24'hFFFFFF, 1, 3'd6, 12'h000, 1, 0);
      issue_alu(1, 0, 24'd0, 1, 3'd7, 12'h000, 1, 0);
      issue_alu(0, 4'd5, 24'd0, 1, 3'd0, 12'h000, 1, 0);
      issue_alu(1, 0, 24'h000010, 1, 3'd7, 12'h000, 1, 0);
      issue_alu(1, 0, 24'h555555, 1, 3'd1, 12'h000, 0, 0);
      idle();
   endtask

   task automatic test_mem_write();
      issue_alu(1, 0, 24'h5A5A5A, 0, 3'd0, 12'h004, 0, 0);
      idle();
      mem_op(0, 1, 2, 24'h111111);
      issue_alu(0, 4'd2, 24'd0, 1, 3'd0, 12'h000, 1, 0);
      mem_op(1, 0, 1, 24'h0C0FFE);
      issue_alu(0, 4'd2, 24'd0, 1, 3'd0, 12'h000, 1, 0);
      idle();
   endtask

   task automatic test_rdwr_conflict();
      issue_alu(1, 0, 24'h20, 0, 3'd0, 12'h002, 0, 0);
      issue_alu(1, 0, 24'h123456, 0, 3'd0, 12'h004, 0, 0);
      idle();
      n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL conflict_pre_perr got=%b want=0", proto_err); end
      mem_op(1, 1, 2, 24'h999999);
      issue_alu(0, 4'd2, 24'd0, 1, 3'd0, 12'h000, 1, 0);
      idle();
   endtask

   task automatic test_bad_src();
      issue_alu(1, 0, 24'h77, 1, 3'd0, 12'h000, 1, 0);
      idle();
      n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL badsrc_pre_perr got=%b want=0", proto_err); end
      issue_alu(0, 4'd13, 24'h77, 1, 3'd1, 12'h000, 1, 0);
      idle();
      n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL badsrc_perr got=%b want=1", proto_err); end
   endtask

   task automatic test_reset_mid();
      issue_alu(1, 0, 24'h33, 0, 3'd0, 12'h00F, 1, 0);
      idle();
      uop_src_imm = 1'b1; uop_mem_rd = 1'b1; uop_valid = 1'b1;
      @(posedge clk); #1;
      uop_valid = 1'b0; uop_mem_rd = 1'b0;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL midrst_req_pre got=%b want=1", mem_req); end
      #1 reset_n = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL midrst_req got=%b want=0", mem_req); end
      n_cmp++; if ({ac_out, pc_out} !== 48'd0) begin n_bad++; $display("FAIL midrst_regs got=%h/%h want=0/0", ac_out, pc_out); end
      n_cmp++; if (uop_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got=%b want=1", uop_ready); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      m_perr = 1'b1;
      n_cmp++; if (proto_err !== m_perr) begin n_bad++; $display("FAIL stray_ack_perr got=%b want=%b", proto_err, m_perr); end
      n_cmp++; if ({uop_ready, mem_req} !== 2'b10) begin n_bad++; $display("FAIL stray_ack_state got=%b want=10", {uop_ready, mem_req}); end
      issue_alu(0, 4'd2, 24'd0, 1, 3'd0, 12'h000, 1, 0);
      issue_alu(0, 4'd3, 24'd0, 1, 3'd1, 12'h000, 1, 0);
      idle();
   endtask

   initial begin
      reset_n = 1'b0; uop_valid = 1'b0; uop_src = '0; uop_src_imm = 1'b1; uop_imm = '0;
      uop_alu_en = 1'b0; uop_alu_op = '0; uop_dst = '0; uop_ac_wr = 1'b0; uop_pc_inc = 1'b0;
      uop_mem_rd = 1'b0; uop_mem_wr = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      model_reset();
      test_reset();
      test_back_to_back();
      test_sub_neg();
      test_mem_read();
      test_pc();
      test_alu_ops();
      test_mem_write();
      test_rdwr_conflict();
      test_reset();
      test_bad_src();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
